sc_char_rx: RTL and testbench
=============================

SC_CHAR_RX -- requirements
Module: sc_char_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, power-of-two count of received-character entries held.
REQ-002 Parameter SYNC_STAGES, default 2, number of io_i synchronizer flops (minimum 2).
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 io_i  input  1  card I/O line level (open-drain, idle high), asynchronous to clk.
REQ-006 io_drive  output  1  1 = pull card I/O low (error signal); 0 = release to high-Z.
REQ-007 rx_en  input  1  1 = start-bit detection enabled.
REQ-008 etu_div  input  12  clk cycles per elementary time unit (ETU); values below 16 are used as 16.
REQ-009 data  output  8  FIFO head character.
REQ-010 valid  output  1  FIFO non-empty; data is valid.
REQ-011 ready  input  1  consumer accepts head when valid & ready.
REQ-012 parity_err  output  1  one-cycle pulse per character with bad parity.
REQ-013 overrun  output  1  sticky: a good character was dropped because the FIFO was full.
REQ-014 clr_ovr  input  1  synchronous clear of overrun.

Function
REQ-015 io_i shall pass through SYNC_STAGES flops; all decoding shall use the synchronized level io_s.
REQ-016 The FSM shall have states IDLE, START, DATA, PARITY, GUARD and NACK.
REQ-017 IDLE: a 1->0 transition of io_s while rx_en=1 shall enter START and clear the ETU counter; that transition cycle is t0.
REQ-018 START: io_s shall be sampled at t0+E/2 (E = effective etu_div, E/2 = E>>1); low -> DATA; high -> IDLE with no output (glitch rejection).
REQ-019 DATA: 8 bits shall be sampled at t0+E/2+k*E, k=1..8, and assembled LSB first (direct convention).
REQ-020 PARITY: the parity bit shall be sampled at t0+E/2+9E; parity is good when the 9 sampled bits contain an even number of ones.
REQ-021 Good parity: the character shall be pushed at the parity sample cycle, then GUARD for E cycles, then IDLE.
REQ-022 Bad parity: parity_err shall pulse at the parity sample cycle, the character shall be discarded, and the FSM shall enter NACK.
REQ-023 NACK shall hold io_drive=1 from t0+10.5E for exactly E cycles, then GUARD for E cycles, then IDLE.
REQ-024 io_drive shall be 1 only in NACK; the FSM shall ignore io_s edges from START through GUARD.
REQ-025 Deasserting rx_en shall affect only IDLE; a character in progress shall complete.
REQ-026 FIFO: first-word fall-through; valid=~empty; pop on valid & ready.
REQ-027 A push when full shall be dropped and shall set overrun, unless a pop occurs in the same cycle, in which case the push shall be accepted.
REQ-028 Simultaneous push and pop on an empty FIFO: valid shall rise the next cycle and data shall be the new character.
REQ-029 If clr_ovr and a new overrun coincide, overrun shall remain 1.
REQ-030 Pointers shall wrap modulo FIFO_DEPTH; occupancy shall use log2(FIFO_DEPTH)+1 bits.

Reset
REQ-031 Asserting rst shall immediately force io_drive=0, valid=0, parity_err=0 and overrun=0, set the FSM to IDLE, empty the FIFO, and preset the synchronizer flops to 1.
REQ-032 Reset mid-character or mid-NACK shall abort that character without a push and release the line in the same cycle.

Configuration
REQ-033 With macro SC_RX_NACK_EN defined, bad parity shall follow REQ-022 to REQ-023.
REQ-034 Without SC_RX_NACK_EN, there shall be no NACK state and io_drive shall be tied to 0; bad parity shall pulse parity_err, discard the character, and go to GUARD.

Verification (etu_div=16, FIFO_DEPTH=4, macro defined unless stated)
REQ-035 Send 0x3B with parity bit 1 -> valid=1 and data=0x3B after the parity sample; io_drive stays 0; parity_err stays 0.
REQ-036 Send 0x3B with parity bit 0 -> parity_err pulses once; io_drive=1 for 16 cycles starting 168 cycles after t0; valid stays 0.
REQ-037 Drive io_i low for 4 cycles, then high -> no push; the FSM is back in IDLE by t0+9.
REQ-038 Send 5 good characters 0x01..0x05 with ready=0 -> FIFO holds 0x01..0x04; overrun=1; clr_ovr clears overrun; with ready=1, 0x01..0x04 pop in order.
REQ-039 Assert rst during NACK -> io_drive=0 in the same cycle; no push; a following good 0xA5 is received correctly.
REQ-040 Build without SC_RX_NACK_EN and send a bad-parity character -> parity_err pulses; io_drive stays 0 throughout.

Source files
------------

// File: rtl/sc_char_rx.sv
// ---------------------------------------------------------------------------
// sc_char_rx -- smart-card character receiver (ISO 7816-3 style, direct
// convention, even parity) with a first-word fall-through receive FIFO.
//
// Optional feature macro: SC_RX_NACK_EN
//   defined   : a bad-parity character is answered with an error signal
//               (io_drive pulls the line low for one ETU, starting 10.5 ETU
//               after the start edge), then one ETU of guard time.
//   undefined : no NACK state, io_drive is tied low, and a bad-parity
//               character goes straight to the guard time.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   io_i          card I/O line level (asynchronous, idle high)
//   io_drive      1 = pull the card I/O line low
//   rx_en         enables start-bit detection
//   etu_div[11:0] clk cycles per ETU (values below 16 act as 16)
//   data[7:0]     FIFO head character, valid while valid=1
//   valid         FIFO not empty
//   ready         consumer takes the head when valid & ready
//   parity_err    one-cycle pulse per bad-parity character
//   overrun       sticky: a good character was dropped on a full FIFO
//   clr_ovr       synchronous clear of overrun
// ---------------------------------------------------------------------------
module sc_char_rx #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_i,
  output logic        io_drive,
  input  logic        rx_en,
  input  logic [11:0] etu_div,
  output logic [7:0]  data,
  output logic        valid,
  input  logic        ready,
  output logic        parity_err,
  output logic        overrun,
  input  logic        clr_ovr
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned OCW     = AW + 1;
  localparam int unsigned CW      = 13;
  localparam int unsigned ETU_MIN = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_GUARD
`ifdef SC_RX_NACK_EN
    , S_NACK
`endif
  } state_t;

  // Synchronizer and edge detect
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_io_d;
  logic                   w_io_s;
  logic                   w_fall;

  assign w_io_s = r_sync[SYNC_STAGES-1];
  assign w_fall = ~w_io_s & r_io_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
      r_io_d <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], io_i};
      r_io_d <= w_io_s;
    end
  end

  // Receiver FSM registers
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [11:0]   r_etu;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_perr;
`ifdef SC_RX_NACK_EN
  logic          r_drive;
`endif

  logic [11:0]   w_etu_eff;
  logic          w_half_tick;
  logic          w_tick;
  logic          w_par_ok;
  logic          w_push;

  assign w_etu_eff   = (etu_div < 12'(ETU_MIN)) ? 12'(ETU_MIN) : etu_div;
  // r_cnt reads n-1 in the n-th cycle after the last restart, so a match on
  // target-1 lands exactly target cycles after that restart.
  assign w_half_tick = (r_cnt == CW'(r_etu >> 1) - CW'(1));
  assign w_tick      = (r_cnt == CW'(r_etu) - CW'(1));
  // Even parity over the 8 data bits plus the parity bit now on the line.
  assign w_par_ok    = ~(^{r_shift, w_io_s});
  assign w_push      = (r_state == S_PARITY) && w_tick && w_par_ok;

`ifdef SC_RX_NACK_EN
  logic w_nack_on;
  logic w_nack_off;
  // Drive is registered, so both edges are decided one cycle early.
  assign w_nack_on  = (r_cnt == CW'(r_etu) - CW'(2));
  assign w_nack_off = (r_cnt == (CW'(r_etu) << 1) - CW'(2));
`endif

  // Character framing state machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_etu   <= 12'(ETU_MIN);
      r_bit   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
`ifdef SC_RX_NACK_EN
      r_drive <= 1'b0;
`endif
    end else begin
      r_perr <= 1'b0;
      r_cnt  <= r_cnt + CW'(1);
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (rx_en && w_fall) begin
            r_state <= S_START;
            r_etu   <= w_etu_eff;
          end
        end
        S_START: begin
          if (w_half_tick) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            // A line already back high mid start bit is a glitch.
            r_state <= w_io_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_shift <= {w_io_s, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              r_state <= S_PARITY;
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (w_par_ok) begin
              r_state <= S_GUARD;
            end else begin
              r_perr  <= 1'b1;
`ifdef SC_RX_NACK_EN
              r_state <= S_NACK;
`else
              r_state <= S_GUARD;
`endif
            end
          end
        end
        S_GUARD: begin
          if (w_tick) begin
            r_state <= S_IDLE;
          end
        end
`ifdef SC_RX_NACK_EN
        S_NACK: begin
          // One ETU of wait after the parity sample, then one ETU of drive.
          if (w_nack_on) begin
            r_drive <= 1'b1;
          end
          if (w_nack_off) begin
            r_drive <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_GUARD;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign parity_err = r_perr;
`ifdef SC_RX_NACK_EN
  assign io_drive   = r_drive;
`else
  assign io_drive   = 1'b0;
`endif

  // Receive FIFO, first-word fall-through
  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [OCW-1:0] r_count;
  logic           r_ovr;

  logic           w_full;
  logic           w_pop;
  logic           w_wr;

  assign valid  = (r_count != '0);
  assign data   = r_mem[r_rd_ptr];
  assign w_full = (r_count == OCW'(FIFO_DEPTH));
  assign w_pop  = valid & ready;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign w_wr   = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + OCW'(1);
        2'b01:   r_count <= r_count - OCW'(1);
        default: r_count <= r_count;
      endcase
      // A new drop wins over a simultaneous clear.
      if (w_push && w_full && !w_pop) begin
        r_ovr <= 1'b1;
      end else if (clr_ovr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign overrun = r_ovr;

endmodule

// File: tb/tb_sc_char_rx.sv
module tb_sc_char_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_i;
  logic        io_drive;
  logic        rx_en;
  logic [11:0] etu_div;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        parity_err;
  logic        overrun;
  logic        clr_ovr;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int drv_total = 0;
  int drv_first = -1;
  int perr_total = 0;
  logic drv_prev = 1'b0;
  int last_c0 = 0;

  logic [7:0] exp_q [$];

  sc_char_rx #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .io_i       (io_i),
    .io_drive   (io_drive),
    .rx_en      (rx_en),
    .etu_div    (etu_div),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .parity_err (parity_err),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: counts drive cycles, first drive cycle and parity pulses.
  always @(negedge clk) begin
    if (io_drive && !drv_prev) drv_first <= cyc;
    if (io_drive) drv_total <= drv_total + 1;
    if (parity_err) perr_total <= perr_total + 1;
    drv_prev <= io_drive;
  end

  function automatic logic even_par(input logic [7:0] b);
    int n = 0;
    for (int i = 0; i < 8; i++) if (b[i]) n++;
    return logic'(n % 2);
  endfunction

  // Drives one frame (start, 8 data LSB first, parity), e cycles per bit.
  // Called on a negedge; clr_ovr is raised during frame cycle clr_at.
  task automatic send(input logic [7:0] b, input logic par, input int e, input int clr_at);
    last_c0 = cyc;
    for (int k = 0; k < 10 * e; k++) begin
      if (k < e) io_i = 1'b0;
      else if (k < 9 * e) io_i = b[(k / e) - 1];
      else io_i = par;
      clr_ovr = (k == clr_at);
      @(negedge clk);
    end
    io_i = 1'b1;
    clr_ovr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; io_i = 1'b1; rx_en = 1'b1; etu_div = 12'd16;
    ready = 1'b0; clr_ovr = 1'b0;
    idle(3);
    checks++;
    if ({io_drive, valid, parity_err, overrun} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got drive/valid/perr/ovr=%b required 0000",
               {io_drive, valid, parity_err, overrun});
    end
    rst = 1'b0;
    idle(4);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_valid: got %b required 0", valid);
    end
  endtask

  task automatic test_good_char;
    int p0 = perr_total;
    int d0 = drv_total;
    send(8'h3B, 1'b1, 16, -1);
    idle(64);
    checks++;
    if (valid !== 1'b1 || data !== 8'h3B) begin
      errors++;
      $display("FAIL good_char: got valid=%b data=%h required valid=1 data=3b", valid, data);
    end
    checks++;
    if (perr_total - p0 != 0 || drv_total - d0 != 0) begin
      errors++;
      $display("FAIL good_char_quiet: got perr=%0d drive=%0d required 0 0",
               perr_total - p0, drv_total - d0);
    end
    ready = 1'b1; idle(1); ready = 1'b0;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL good_char_pop: got valid=%b required 0", valid);
    end
  endtask

  task automatic test_bad_char;
    int p0 = perr_total;
    int d0 = drv_total;
    send(8'h3B, 1'b0, 16, -1);
    idle(64);
    checks++;
    if (perr_total - p0 != 1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_char: got perr_pulses=%0d valid=%b required 1 0", perr_total - p0, valid);
    end
`ifdef SC_RX_NACK_EN
    checks++;
    if (drv_total - d0 != 16 || drv_first != last_c0 + 2 + 168) begin
      errors++;
      $display("FAIL nack_window: got len=%0d start=t0+%0d required len=16 start=t0+168",
               drv_total - d0, drv_first - last_c0 - 2);
    end
`else
    checks++;
    if (drv_total - d0 != 0) begin
      errors++;
      $display("FAIL no_nack_drive: got %0d drive cycles required 0", drv_total - d0);
    end
`endif
  endtask

  task automatic test_glitch;
    int p0 = perr_total;
    logic [7:0] b = 8'($urandom);
    // 4-cycle glitch, then a real start edge 9 cycles after the glitch edge.
    io_i = 1'b0; idle(4);
    io_i = 1'b1; idle(5);
    send(b, even_par(b), 16, -1);
    idle(40);
    checks++;
    if (valid !== 1'b1 || data !== b || perr_total != p0) begin
      errors++;
      $display("FAIL glitch_then_char: got valid=%b data=%h perr=%0d required 1 %h 0",
               valid, data, perr_total - p0, b);
    end
    ready = 1'b1; idle(1); ready = 1'b0;
    // rx_en low: a whole frame is ignored.
    rx_en = 1'b0;
    send(8'h55, even_par(8'h55), 16, -1);
    idle(40);
    rx_en = 1'b1;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_en_off: got valid=%b required 0", valid);
    end
  endtask

  task automatic test_etu;
    logic [7:0] b;
    b = 8'($urandom);
    etu_div = 12'd20;
    send(b, even_par(b), 20, -1);
    idle(60);
    checks++;
    if (valid !== 1'b1 || data !== b) begin
      errors++;
      $display("FAIL etu20: got valid=%b data=%h required 1 %h", valid, data, b);
    end
    ready = 1'b1; idle(1); ready = 1'b0;
    b = 8'($urandom);
    etu_div = 12'd3;
    send(b, even_par(b), 16, -1);
    idle(60);
    checks++;
    if (valid !== 1'b1 || data !== b) begin
      errors++;
      $display("FAIL etu_clamp: got valid=%b data=%h required 1 %h", valid, data, b);
    end
    ready = 1'b1; idle(1); ready = 1'b0;
    etu_div = 12'd16;
  endtask

  task automatic test_overrun;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), even_par(8'(i)), 16, -1);
      idle(40);
      if (i == 4) begin
        checks++;
        if (overrun !== 1'b0) begin
          errors++;
          $display("FAIL full_no_overrun: got %b required 0", overrun);
        end
      end
    end
    checks++;
    if (overrun !== 1'b1 || valid !== 1'b1 || data !== 8'h01) begin
      errors++;
      $display("FAIL overrun_set: got ovr=%b valid=%b data=%h required 1 1 01", overrun, valid, data);
    end
    clr_ovr = 1'b1; idle(1); clr_ovr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %b required 0", overrun);
    end
    // clr_ovr exactly in the drop cycle (t0+152 = frame cycle 154).
    send(8'h06, even_par(8'h06), 16, 154);
    idle(40);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_clr_collision: got %b required 1", overrun);
    end
    clr_ovr = 1'b1; idle(1); clr_ovr = 1'b0;
    ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (valid !== 1'b1 || data !== 8'(i)) begin
        errors++;
        $display("FAIL overrun_drain_%0d: got valid=%b data=%h required 1 %h", i, valid, data, 8'(i));
      end
      idle(1);
    end
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_empty: got valid=%b ovr=%b required 0 0", valid, overrun);
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 4; r++) begin
      int n = int'($urandom_range(1, 4));
      int bad = 0;
      int p0 = perr_total;
      int guard = 0;
      for (int j = 0; j < n; j++) begin
        logic [7:0] b = 8'($urandom);
        logic good = ($urandom_range(0, 3) != 0);
        send(b, good ? even_par(b) : ~even_par(b), 16, -1);
        idle(70);
        if (good) exp_q.push_back(b);
        else bad++;
      end
      checks++;
      if (perr_total - p0 != bad) begin
        errors++;
        $display("FAIL random_perr_%0d: got %0d required %0d", r, perr_total - p0, bad);
      end
      while ((exp_q.size() != 0 || valid) && guard < 60) begin
        ready = logic'($urandom_range(0, 1));
        if (ready && valid) begin
          checks++;
          if (exp_q.size() == 0 || data !== exp_q[0]) begin
            errors++;
            $display("FAIL random_data_%0d: got %h required %h", r, data,
                     exp_q.size() != 0 ? exp_q[0] : 8'h00);
          end
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        idle(1);
        guard++;
      end
      ready = 1'b0;
      checks++;
      if (exp_q.size() != 0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL random_drain_%0d: got left=%0d valid=%b required 0 0", r, exp_q.size(), valid);
      end
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    int guard = 0;
    send(8'h3B, 1'b0, 16, -1);
`ifdef SC_RX_NACK_EN
    while (io_drive !== 1'b1 && guard < 50) begin idle(1); guard++; end
    checks++;
    if (io_drive !== 1'b1) begin
      errors++;
      $display("FAIL nack_wait: got io_drive=%b required 1 within 50 cycles", io_drive);
    end
`else
    idle(2);
`endif
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({io_drive, valid, parity_err, overrun} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid: got drive/valid/perr/ovr=%b required 0000",
               {io_drive, valid, parity_err, overrun});
    end
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    send(8'hA5, even_par(8'hA5), 16, -1);
    idle(40);
    checks++;
    if (valid !== 1'b1 || data !== 8'hA5) begin
      errors++;
      $display("FAIL after_reset_char: got valid=%b data=%h required 1 a5", valid, data);
    end
    ready = 1'b1; idle(1); ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_good_char();
    test_bad_char();
    test_glitch();
    test_etu();
    test_overrun();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
